blut_pc_ctrl: RTL and testbench

- Program-counter / fetch controller that initiates requests on the branch lookup table port.
- At boot it streams (index, target) pairs into the table as its writer. It then runs the PC, issuing table reads for taken branches and redirecting to the returned target.
- Sits between the instruction decoder and the branch LUT. It is the only master of the table's index, write-enable and write-data lines.

---
 rtl/blut_pkg.sv | 22 ++
 rtl/blut_loader.sv | 51 +++++
 rtl/blut_pc_ctrl.sv | 175 +++++++++++++++++
 tb/tb_blut_pc_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/blut_pkg.sv
// Shared definitions for the branch-LUT program-counter controller.
//   state_e   : controller FSM states
//   PC_W_DEF  : default program counter / target width
//   IDX_W_DEF : default branch table index width
//   pc_t, lut_idx_t : convenience types at the default widths
package blut_pkg;

  localparam int PC_W_DEF  = 10;
  localparam int IDX_W_DEF = 5;

  typedef logic [PC_W_DEF-1:0]  pc_t;
  typedef logic [IDX_W_DEF-1:0] lut_idx_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RUN    = 3'd2,
    LOOKUP = 3'd3,
    HALTED = 3'd4
  } state_e;

endpackage

// File: rtl/blut_loader.sv
// Boot-time table loader: turns the (index, target) load stream into
// single-cycle table write strobes while the controller is in LOAD.
// Ports:
//   en_i          controller is in LOAD
//   load_valid_i  stream entry valid
//   load_index_i  slot to write
//   load_target_i target address for that slot
//   load_last_i   final entry marker
//   load_ready_o  entry accepted (high for the whole LOAD state)
//   wr_en_o       table write strobe
//   wr_idx_o      table write index (0 when not writing)
//   wr_data_o     table write data  (0 when not writing)
//   last_o        final legal entry accepted this cycle
//   err_o         out-of-range entry seen (only when RANGE_EN)
module blut_loader
  import blut_pkg::*;
#(
  parameter int          PC_W       = PC_W_DEF,
  parameter int          IDX_W      = IDX_W_DEF,
  parameter int unsigned PROG_DEPTH = 1024,
  parameter bit          RANGE_EN   = 1'b0
) (
  input  logic             en_i,
  input  logic             load_valid_i,
  input  logic [IDX_W-1:0] load_index_i,
  input  logic [PC_W-1:0]  load_target_i,
  input  logic             load_last_i,
  output logic             load_ready_o,
  output logic             wr_en_o,
  output logic [IDX_W-1:0] wr_idx_o,
  output logic [PC_W-1:0]  wr_data_o,
  output logic             last_o,
  output logic             err_o
);

  logic accept;
  logic illegal;

  assign accept  = en_i & load_valid_i;
  // An illegal entry is dropped rather than written so the table never
  // holds an address outside the program.
  assign illegal = RANGE_EN && (32'(load_target_i) >= PROG_DEPTH);

  assign load_ready_o = en_i;
  assign wr_en_o      = accept & ~illegal;
  assign wr_idx_o     = wr_en_o ? load_index_i  : '0;
  assign wr_data_o    = wr_en_o ? load_target_i : '0;
  assign last_o       = accept & load_last_i & ~illegal;
  assign err_o        = accept & illegal;

endmodule

// File: rtl/blut_pc_ctrl.sv
// Program-counter / fetch controller and sole master of the branch LUT.
// After start it loads (index, target) pairs into the table, then runs the
// PC; taken branches read the table and redirect to the returned target
// with a single bubble cycle.
// Optional feature: define BLUT_PC_RANGE_CHECK_EN to flag load targets or
// returned branch targets >= PROG_DEPTH (sticky error, move to HALTED).
// Without it error stays 0 and addresses wrap modulo 2^PC_W.
// Ports:
//   clk, reset (sync, active-high)
//   start                               leave IDLE/HALTED, begin table load
//   load_valid/index/target/last, load_ready   load stream handshake
//   branch_req/taken/index              decoder branch information
//   stall, halt                         pipeline hold / stop
//   lut_index, lut_write_enable, lut_target_address   table master lines
//   branch_target                       registered table read data
//   pc, fetch_valid                     fetch address and qualifier
//   done, error                         halted / range violation
module blut_pc_ctrl
  import blut_pkg::*;
#(
  parameter int          PC_W       = PC_W_DEF,
  parameter int          IDX_W      = IDX_W_DEF,
  parameter int unsigned START_PC   = 0,
  parameter int unsigned PROG_DEPTH = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             load_valid,
  input  logic [IDX_W-1:0] load_index,
  input  logic [PC_W-1:0]  load_target,
  input  logic             load_last,
  output logic             load_ready,
  input  logic             branch_req,
  input  logic             branch_taken,
  input  logic [IDX_W-1:0] branch_index,
  input  logic             stall,
  input  logic             halt,
  output logic [IDX_W-1:0] lut_index,
  output logic             lut_write_enable,
  output logic [PC_W-1:0]  lut_target_address,
  input  logic [PC_W-1:0]  branch_target,
  output logic [PC_W-1:0]  pc,
  output logic             fetch_valid,
  output logic             done,
  output logic             error
);

`ifdef BLUT_PC_RANGE_CHECK_EN
  localparam bit RangeEn = 1'b1;
`else
  localparam bit RangeEn = 1'b0;
`endif

  state_e           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             error_q, error_d;

  logic             ld_en, ld_we, ld_last, ld_err;
  logic [IDX_W-1:0] ld_idx;
  logic [PC_W-1:0]  ld_data;
  logic             tgt_bad;

  assign ld_en = (state_q == LOAD);

  blut_loader #(
    .PC_W       (PC_W),
    .IDX_W      (IDX_W),
    .PROG_DEPTH (PROG_DEPTH),
    .RANGE_EN   (RangeEn)
  ) u_loader (
    .en_i          (ld_en),
    .load_valid_i  (load_valid),
    .load_index_i  (load_index),
    .load_target_i (load_target),
    .load_last_i   (load_last),
    .load_ready_o  (load_ready),
    .wr_en_o       (ld_we),
    .wr_idx_o      (ld_idx),
    .wr_data_o     (ld_data),
    .last_o        (ld_last),
    .err_o         (ld_err)
  );

  assign tgt_bad = RangeEn && (32'(branch_target) >= PROG_DEPTH);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      idx_q   <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      idx_q   <= idx_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    state_d            = state_q;
    pc_d               = pc_q;
    idx_d              = idx_q;
    error_d            = error_q;
    fetch_valid        = 1'b0;
    done               = 1'b0;
    lut_index          = '0;
    lut_write_enable   = 1'b0;
    lut_target_address = '0;

    unique case (state_q)
      IDLE: begin
        if (start) state_d = LOAD;
      end

      LOAD: begin
        lut_write_enable   = ld_we;
        lut_index          = ld_idx;
        lut_target_address = ld_data;
        if (ld_err) begin
          error_d = 1'b1;
          state_d = HALTED;
        end else if (ld_last) begin
          pc_d    = PC_W'(START_PC);
          state_d = RUN;
        end
      end

      RUN: begin
        fetch_valid = ~stall;
        if (halt) begin
          state_d = HALTED;
        end else if (stall) begin
          state_d = RUN;
        end else if (branch_req && branch_taken) begin
          // Present the index now; the table returns the target next cycle.
          lut_index = branch_index;
          idx_d     = branch_index;
          state_d   = LOOKUP;
        end else begin
          pc_d = pc_q + PC_W'(1);
        end
      end

      LOOKUP: begin
        // Keep presenting the index so a stalled lookup re-reads the table.
        lut_index = idx_q;
        if (halt) begin
          state_d = HALTED;
        end else if (!stall) begin
          if (tgt_bad) begin
            error_d = 1'b1;
            state_d = HALTED;
          end else begin
            pc_d    = branch_target;
            state_d = RUN;
          end
        end
      end

      HALTED: begin
        done = 1'b1;
        if (start) state_d = LOAD;
      end

      default: state_d = IDLE;
    endcase
  end

  assign pc    = pc_q;
  assign error = error_q;

endmodule

// File: tb/tb_blut_pc_ctrl.sv
module tb_blut_pc_ctrl;
  import blut_pkg::*;

`ifdef BLUT_PC_RANGE_CHECK_EN
  localparam int unsigned DEPTH = 256;
`else
  localparam int unsigned DEPTH = 1024;
`endif

  logic     clk = 1'b0;
  logic     reset, start, load_valid, load_last, load_ready;
  lut_idx_t load_index, branch_index, lut_index;
  pc_t      load_target, lut_target_address, branch_target, pc;
  logic     branch_req, branch_taken, stall, halt;
  logic     lut_write_enable, fetch_valid, done, error;

  int checks = 0;
  int errors = 0;

  // Behavioural branch table: write on strobe, registered read otherwise.
  pc_t lut_mem [32];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (lut_write_enable) lut_mem[lut_index] <= lut_target_address;
    else                  branch_target      <= lut_mem[lut_index];
  end

  blut_pc_ctrl #(
    .PC_W       (10),
    .IDX_W      (5),
    .START_PC   (0),
    .PROG_DEPTH (DEPTH)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .start              (start),
    .load_valid         (load_valid),
    .load_index         (load_index),
    .load_target        (load_target),
    .load_last          (load_last),
    .load_ready         (load_ready),
    .branch_req         (branch_req),
    .branch_taken       (branch_taken),
    .branch_index       (branch_index),
    .stall              (stall),
    .halt               (halt),
    .lut_index          (lut_index),
    .lut_write_enable   (lut_write_enable),
    .lut_target_address (lut_target_address),
    .branch_target      (branch_target),
    .pc                 (pc),
    .fetch_valid        (fetch_valid),
    .done               (done),
    .error              (error)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change right after the falling edge; checks run 1 time unit later,
  // well clear of the next rising edge.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic load_entry(input logic [4:0] idx, input logic [9:0] tgt, input logic last);
    load_valid  = 1'b1;
    load_index  = idx;
    load_target = tgt;
    load_last   = last;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) lut_mem[i] = '0;
    branch_target = '0;
    reset = 1'b1; start = 1'b0;
    load_valid = 1'b0; load_index = '0; load_target = '0; load_last = 1'b0;
    branch_req = 1'b0; branch_taken = 1'b0; branch_index = '0;
    stall = 1'b0; halt = 1'b0;

    cyc(); cyc(); settle();
    chk("rst_pc",    32'(pc), 32'h0);
    chk("rst_ready", 32'(load_ready), 32'h0);
    chk("rst_we",    32'(lut_write_enable), 32'h0);
    chk("rst_fv",    32'(fetch_valid), 32'h0);
    chk("rst_done",  32'(done), 32'h0);
    chk("rst_err",   32'(error), 32'h0);
    chk("rst_idx",   32'(lut_index), 32'h0);
    chk("rst_data",  32'(lut_target_address), 32'h0);

    reset = 1'b0;
    cyc(); start = 1'b1;
    cyc(); start = 1'b0;
`ifndef BLUT_PC_RANGE_CHECK_EN
    // Table load: three single-cycle write strobes.
    load_entry(5'd2, 10'h040, 1'b0); settle();
    chk("ld0_ready", 32'(load_ready), 32'h1);
    chk("ld0_we",    32'(lut_write_enable), 32'h1);
    chk("ld0_idx",   32'(lut_index), 32'd2);
    chk("ld0_data",  32'(lut_target_address), 32'h040);
    cyc(); load_entry(5'd5, 10'h100, 1'b0); settle();
    chk("ld1_we",    32'(lut_write_enable), 32'h1);
    chk("ld1_idx",   32'(lut_index), 32'd5);
    chk("ld1_data",  32'(lut_target_address), 32'h100);
    cyc(); load_entry(5'd31, 10'h3FF, 1'b1); settle();
    chk("ld2_we",    32'(lut_write_enable), 32'h1);
    chk("ld2_idx",   32'(lut_index), 32'd31);
    chk("ld2_data",  32'(lut_target_address), 32'h3FF);
    cyc(); load_valid = 1'b0; load_last = 1'b0; settle();

    // Sequential run from START_PC.
    chk("run_pc0",  32'(pc), 32'h0);
    chk("run_fv0",  32'(fetch_valid), 32'h1);
    chk("run_we0",  32'(lut_write_enable), 32'h0);
    chk("run_rdy0", 32'(load_ready), 32'h0);
    cyc(); settle(); chk("run_pc1", 32'(pc), 32'h1);
    cyc(); settle(); chk("run_pc2", 32'(pc), 32'h2);
    cyc(); settle(); chk("run_pc3", 32'(pc), 32'h3);
    chk("run_fv3", 32'(fetch_valid), 32'h1);

    // Taken branch via slot 5: one bubble, then 0x100.
    branch_req = 1'b1; branch_taken = 1'b1; branch_index = 5'd5; settle();
    chk("br_idx_issue", 32'(lut_index), 32'd5);
    chk("br_we_issue",  32'(lut_write_enable), 32'h0);
    cyc(); branch_req = 1'b0; branch_taken = 1'b0; settle();
    chk("lk_fv",  32'(fetch_valid), 32'h0);
    chk("lk_idx", 32'(lut_index), 32'd5);
    chk("lk_pc",  32'(pc), 32'h3);
    cyc(); settle();
    chk("br_pc", 32'(pc), 32'h100);
    chk("br_fv", 32'(fetch_valid), 32'h1);

    // Not-taken branch falls through.
    branch_req = 1'b1; branch_taken = 1'b0; branch_index = 5'd2;
    cyc(); settle();
    chk("nt_pc", 32'(pc), 32'h101);

    // Taken branch via slot 2 with a two-cycle stall inside LOOKUP.
    branch_req = 1'b1; branch_taken = 1'b1; branch_index = 5'd2;
    cyc(); branch_req = 1'b0; branch_taken = 1'b0; stall = 1'b1; settle();
    chk("lkst1_fv",  32'(fetch_valid), 32'h0);
    chk("lkst1_idx", 32'(lut_index), 32'd2);
    chk("lkst1_pc",  32'(pc), 32'h101);
    cyc(); settle();
    chk("lkst2_pc",  32'(pc), 32'h101);
    chk("lkst2_idx", 32'(lut_index), 32'd2);
    cyc(); stall = 1'b0; settle();
    chk("lkst3_pc",  32'(pc), 32'h101);
    cyc(); settle();
    chk("lkst_tgt",  32'(pc), 32'h040);

    // Stall in RUN masks a taken branch.
    stall = 1'b1; branch_req = 1'b1; branch_taken = 1'b1; branch_index = 5'd31; settle();
    chk("rst_fv_stall", 32'(fetch_valid), 32'h0);
    cyc(); settle();
    chk("stall_pc_hold", 32'(pc), 32'h040);
    chk("stall_fv",      32'(fetch_valid), 32'h0);
    stall = 1'b0; settle();
    chk("br31_idx", 32'(lut_index), 32'd31);
    cyc(); branch_req = 1'b0; branch_taken = 1'b0; settle();
    chk("br31_lk_fv", 32'(fetch_valid), 32'h0);
    cyc(); settle();
    chk("br31_pc", 32'(pc), 32'h3FF);

    // Wrap from the top of the address space.
    cyc(); settle();
    chk("wrap_pc", 32'(pc), 32'h000);

    // Halt wins over a simultaneous taken branch.
    halt = 1'b1; branch_req = 1'b1; branch_taken = 1'b1; branch_index = 5'd5; settle();
    chk("halt_no_lookup_idx", 32'(lut_index), 32'd0);
    cyc(); halt = 1'b0; branch_req = 1'b0; branch_taken = 1'b0; settle();
    chk("halt_done", 32'(done), 32'h1);
    chk("halt_fv",   32'(fetch_valid), 32'h0);
    chk("halt_pc",   32'(pc), 32'h000);
    cyc(); settle();
    chk("halt_idx", 32'(lut_index), 32'd0);
    chk("halt_done2", 32'(done), 32'h1);

    // Reload from HALTED, then reset in the middle of the load.
    start = 1'b1;
    cyc(); start = 1'b0; settle();
    chk("reload_done",  32'(done), 32'h0);
    chk("reload_ready", 32'(load_ready), 32'h1);
    load_entry(5'd3, 10'h123, 1'b0); reset = 1'b1;
    cyc(); reset = 1'b0; load_valid = 1'b0; settle();
    chk("midrst_ready", 32'(load_ready), 32'h0);
    chk("midrst_we",    32'(lut_write_enable), 32'h0);
    chk("midrst_pc",    32'(pc), 32'h0);
    chk("midrst_done",  32'(done), 32'h0);
    chk("midrst_idx",   32'(lut_index), 32'd0);
    chk("midrst_err",   32'(error), 32'h0);
`else
    // Out-of-range load target: dropped, sticky error, halted.
    load_entry(5'd4, 10'h180, 1'b0); settle();
    chk("rc_ready", 32'(load_ready), 32'h1);
    chk("rc_no_we", 32'(lut_write_enable), 32'h0);
    cyc(); load_valid = 1'b0; settle();
    chk("rc_err",  32'(error), 32'h1);
    chk("rc_done", 32'(done), 32'h1);
    chk("rc_fv",   32'(fetch_valid), 32'h0);
    start = 1'b1;
    cyc(); start = 1'b0; settle();
    chk("rc_err_sticky", 32'(error), 32'h1);
    chk("rc_reload",     32'(load_ready), 32'h1);
    load_entry(5'd4, 10'h080, 1'b0); settle();
    chk("rc_legal_we",   32'(lut_write_enable), 32'h1);
    chk("rc_legal_data", 32'(lut_target_address), 32'h080);
    reset = 1'b1;
    cyc(); reset = 1'b0; load_valid = 1'b0; settle();
    chk("rc_rst_err",   32'(error), 32'h0);
    chk("rc_rst_ready", 32'(load_ready), 32'h0);
    chk("rc_rst_done",  32'(done), 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
